// File: rtl/sr_cmd_gen.sv
// Pushbutton front end for the gated SR latch: synchronise, debounce and edge-detect two buttons,
// then emit arbitrated, mutually exclusive s/r pulses qualified by en.
module sr_cmd_gen #(
    parameter int DB_CYCLES       = 16,
    parameter int PULSE_LEN       = 2,
    parameter int GAP_LEN         = 1,
    parameter int CONFLICT_POLICY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_rst,
    output logic s,
    output logic r,
    output logic en,
    output logic conflict,
    output logic dropped
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    localparam int PG_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int PC_W   = (PG_MAX > 1) ? $clog2(PG_MAX) : 1;
    localparam logic [PC_W-1:0] PULSE_LAST = PC_W'(PULSE_LEN - 1);
    localparam logic [PC_W-1:0] GAP_LAST   = PC_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam logic SET_WINS = (CONFLICT_POLICY == 1);
    localparam logic RST_WINS = (CONFLICT_POLICY == 2);

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {btn_rst, btn_set};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic            sync1_q;
            logic            sync2_q;
            logic            db_q;
            logic            db_prev_q;
            logic            press_q;
            logic [DB_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= btn_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Any cycle where the synchronised level agrees with db restarts the stability count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_q  <= 1'b0;
                    cnt_q <= '0;
                end else if (sync2_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    db_q  <= ~db_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DB_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    db_prev_q <= 1'b0;
                    press_q   <= 1'b0;
                end else begin
                    db_prev_q <= db_q;
                    press_q   <= db_q & ~db_prev_q;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pcnt_q, pcnt_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            en_q, en_d;
    logic            conflict_q, conflict_d;
    logic            dropped_q, dropped_d;
    logic            want_set;
    logic            want_rst;

    // A same-cycle pair only yields a command when the policy names a winner.
    assign want_set = press[0] & (~press[1] | SET_WINS);
    assign want_rst = press[1] & (~press[0] | RST_WINS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            en_q       <= 1'b0;
            conflict_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            s_q        <= s_d;
            r_q        <= r_d;
            en_q       <= en_d;
            conflict_q <= conflict_d;
            dropped_q  <= dropped_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        s_d        = s_q;
        r_d        = r_q;
        en_d       = en_q;
        conflict_d = 1'b0;
        dropped_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                s_d        = 1'b0;
                r_d        = 1'b0;
                en_d       = 1'b0;
                pcnt_d     = '0;
                conflict_d = press[0] & press[1];
                if (want_set || want_rst) begin
                    state_d = ST_PULSE;
                    en_d    = 1'b1;
                    s_d     = want_set;
                    r_d     = want_rst;
                end
            end
            ST_PULSE: begin
                dropped_d = |press;
                if (pcnt_q == PULSE_LAST) begin
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                    en_d    = 1'b0;
                    pcnt_d  = '0;
                    state_d = (GAP_LEN == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            ST_GAP: begin
                dropped_d = |press;
                s_d       = 1'b0;
                r_d       = 1'b0;
                en_d      = 1'b0;
                if (pcnt_q == GAP_LAST) begin
                    pcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = '0;
                s_d     = 1'b0;
                r_d     = 1'b0;
                en_d    = 1'b0;
            end
        endcase
    end

    assign s        = s_q;
    assign r        = r_q;
    assign en       = en_q;
    assign conflict = conflict_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Three differently configured command generators share one pair of buttons and are compared every
// cycle against a timeline model built from the debounce window and pulse/gap durations.
module tb_sr_cmd_gen;

    localparam int DB   = 16;
    localparam int MAXC = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_set = 1'b0;
    logic       btn_rst = 1'b0;
    logic [2:0] s_o, r_o, en_o, cf_o, dr_o;

    always #5 clk = ~clk;

    // a: defaults / reject both; b: reset wins; c: long pulse, no gap, set wins
    sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(2), .GAP_LEN(1), .CONFLICT_POLICY(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
        .s(s_o[0]), .r(r_o[0]), .en(en_o[0]), .conflict(cf_o[0]), .dropped(dr_o[0]));
    sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(2), .GAP_LEN(1), .CONFLICT_POLICY(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
        .s(s_o[1]), .r(r_o[1]), .en(en_o[1]), .conflict(cf_o[1]), .dropped(dr_o[1]));
    sr_cmd_gen #(.DB_CYCLES(DB), .PULSE_LEN(3), .GAP_LEN(0), .CONFLICT_POLICY(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_rst(btn_rst),
        .s(s_o[2]), .r(r_o[2]), .en(en_o[2]), .conflict(cf_o[2]), .dropped(dr_o[2]));

    int cfg_p[3]   = '{2, 2, 3};
    int cfg_g[3]   = '{1, 1, 0};
    int cfg_pol[3] = '{0, 2, 1};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: raw samples per edge since reset release, debounced level after each edge,
    // and per instance the start edge of the last command and the first edge it is idle again.
    int   k;
    logic raw_m [2][MAXC];
    logic db_m  [2][MAXC];
    int   start_m[3];
    int   kind_m[3];
    int   free_m[3];

    function automatic logic get_raw(input int ch, input int idx);
        return (idx < 0) ? 1'b0 : raw_m[ch][idx];
    endfunction

    function automatic logic get_db(input int ch, input int idx);
        return (idx < 0) ? 1'b0 : db_m[ch][idx];
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 3; i++) begin
            start_m[i] = -1000;
            kind_m[i]  = 0;
            free_m[i]  = 0;
        end
    endtask

    task automatic model_edge(input logic bs, input logic br);
        logic ps, pr, lvl, prev, stable, en_e, cf_e, dr_e;
        logic [4:0] exp_v;
        logic [4:0] got_v;
        if (k >= MAXC) begin
            $display("FAIL model_overflow: got %0d expected below %0d", k, MAXC);
            $fatal(1);
        end
        raw_m[0][k] = bs;
        raw_m[1][k] = br;
        // The level seen by the debouncer at edge k was sampled two edges earlier.
        for (int ch = 0; ch < 2; ch++) begin
            lvl  = get_raw(ch, k - 2);
            prev = get_db(ch, k - 1);
            stable = 1'b1;
            for (int j = 0; j < DB; j++)
                if (get_raw(ch, k - 2 - j) != lvl) stable = 1'b0;
            db_m[ch][k] = (lvl != prev && stable) ? lvl : prev;
        end
        ps = get_db(0, k - 2) & ~get_db(0, k - 3);
        pr = get_db(1, k - 2) & ~get_db(1, k - 3);
        for (int i = 0; i < 3; i++) begin
            cf_e = 1'b0;
            dr_e = 1'b0;
            if (ps || pr) begin
                if (k < free_m[i]) begin
                    dr_e = 1'b1;
                end else begin
                    cf_e = ps & pr;
                    if (!(ps && pr) || cfg_pol[i] != 0) begin
                        start_m[i] = k;
                        if (ps && pr) kind_m[i] = (cfg_pol[i] == 1) ? 0 : 1;
                        else          kind_m[i] = ps ? 0 : 1;
                        free_m[i] = k + cfg_p[i] + cfg_g[i] + 1;
                    end
                end
            end
            en_e  = (k >= start_m[i]) && (k < start_m[i] + cfg_p[i]);
            exp_v = {en_e, en_e && kind_m[i] == 0, en_e && kind_m[i] == 1, cf_e, dr_e};
            got_v = {en_o[i], s_o[i], r_o[i], cf_o[i], dr_o[i]};
            check_eq($sformatf("out%0d_k%0d", i, k), 32'(got_v), 32'(exp_v));
        end
        k++;
    endtask

    task automatic check_invariants();
        for (int i = 0; i < 3; i++) begin
            logic bad;
            bad = (s_o[i] & r_o[i]) | ((s_o[i] | r_o[i]) ^ en_o[i]) | (cf_o[i] & dr_o[i]);
            check_eq($sformatf("inv%0d", i), 32'(bad), 32'd0);
        end
    endtask

    task automatic step(input logic bs, input logic br);
        btn_set = bs;
        btn_rst = br;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("rst%0d", i),
                         32'({en_o[i], s_o[i], r_o[i], cf_o[i], dr_o[i]}), 32'd0);
        end else begin
            model_edge(bs, br);
        end
        check_invariants();
    endtask

    initial begin
        logic found;
        model_reset();

        // Held set button through reset, then release
        rst_n = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (30) step(1'b1, 1'b0);

        // Single clean set press
        repeat (30) step(1'b0, 1'b0);
        repeat (40) step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);

        // Bouncing reset button, then held
        repeat (6) begin
            repeat (5) step(1'b0, 1'b1);
            repeat (5) step(1'b0, 1'b0);
        end
        repeat (30) step(1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0);

        // Same-edge presses
        repeat (30) step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0);

        // Reset press landing inside the set pulse
        step(1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b1);
        repeat (30) step(1'b0, 1'b0);

        // Random hold lengths around the debounce window
        repeat (150) begin
            logic bs, br;
            int   len;
            bs  = 1'($urandom_range(0, 1));
            br  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            repeat (len) step(bs, br);
        end

        // Asynchronous reset while a pulse is active
        repeat (30) step(1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b1, 1'b0);
            found = en_o[0];
        end
        check_eq("wait_en", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'({en_o, s_o, r_o, cf_o, dr_o}), 32'd0);
        repeat (2) step(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) step(1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
